// File: rtl/cfg_pkg.sv
// Shared types and constants for the tile-buffer command writer.
// Macro CFG_BUF_WRITER_CLEAR_EN adds the CLEAR state.
package cfg_pkg;

    localparam int CFG_COLS      = 40;
    localparam int CFG_ROWS      = 23;
    localparam int CFG_BUF_DEPTH = 920;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_FILL  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } cfg_op_t;

`ifdef CFG_BUF_WRITER_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } cfg_state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cfg_state_t;
`endif

endpackage

// File: rtl/cfg_addr_calc.sv
// Linear tile address (row*COLS+col) by shift-add, plus range check.
// Purely combinational.
module cfg_addr_calc
    import cfg_pkg::*;
#(
    parameter int COLS = CFG_COLS,
    parameter int ROWS = CFG_ROWS
) (
    input  logic [4:0] row_in,
    input  logic [5:0] col_in,
    output logic [9:0] addr_out,
    output logic       range_err_out
);

    // Sum row shifted by each set bit of COLS, then add the column
    always_comb begin
        addr_out = {4'd0, col_in};
        for (int i = 0; i < 10; i++) begin
            if (COLS[i]) begin
                addr_out = addr_out + ({5'd0, row_in} << i);
            end
        end
        range_err_out = ({27'd0, row_in} >= 32'(ROWS)) ||
                        ({26'd0, col_in} >= 32'(COLS));
    end

endmodule

// File: rtl/config_buf_writer.sv
// Command-driven tile buffer writer: WRITE, FILL and optional CLEAR.
// Macro CFG_BUF_WRITER_CLEAR_EN enables op 2 (CLEAR).
module config_buf_writer
    import cfg_pkg::*;
#(
    parameter int COLS = CFG_COLS,
    parameter int ROWS = CFG_ROWS
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cmd_valid_in,
    output logic       cmd_ready_out,
    input  logic [1:0] cmd_op_in,
    input  logic [4:0] cmd_row_in,
    input  logic [5:0] cmd_col_in,
    input  logic [5:0] cmd_len_in,
    input  logic [7:0] cmd_data_in,
    output logic       buf_write_valid_out,
    output logic [9:0] buf_write_addr_out,
    output logic [7:0] buf_write_data_out,
    output logic       done_out,
    output logic       err_out
);

    localparam logic [9:0] LAST_ADDR = 10'(ROWS * COLS - 1);

    cfg_state_t state_q, state_d;
    logic       valid_q, valid_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [5:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [9:0] calc_addr;
    logic       range_err;
    logic [5:0] len_sel;
    cfg_op_t    op;
`ifdef CFG_BUF_WRITER_CLEAR_EN
    logic [9:0] clr_q, clr_d;
`endif

    cfg_addr_calc #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_addr_calc (
        .row_in       (cmd_row_in),
        .col_in       (cmd_col_in),
        .addr_out     (calc_addr),
        .range_err_out(range_err)
    );

    assign op      = cfg_op_t'(cmd_op_in);
    assign len_sel = (op == OP_WRITE) ? 6'd1 : cmd_len_in;

    assign cmd_ready_out       = (state_q == ST_IDLE);
    assign buf_write_valid_out = valid_q;
    assign buf_write_addr_out  = addr_q;
    assign buf_write_data_out  = data_q;
    assign done_out            = done_q;
    assign err_out             = err_q;

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CFG_BUF_WRITER_CLEAR_EN
        clr_d   = clr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_in) begin
                    case (op)
                        OP_WRITE, OP_FILL: begin
                            if (range_err) begin
                                err_d = 1'b1;
                            end else if (len_sel == 6'd0) begin
                                done_d = 1'b1;
                            end else begin
                                valid_d = 1'b1;
                                addr_d  = calc_addr;
                                data_d  = cmd_data_in;
                                cnt_d   = len_sel - 6'd1;
                                state_d = ST_RUN;
                            end
                        end
`ifdef CFG_BUF_WRITER_CLEAR_EN
                        OP_CLEAR: begin
                            valid_d = 1'b1;
                            addr_d  = 10'd0;
                            data_d  = cmd_data_in;
                            clr_d   = 10'(CFG_BUF_DEPTH - 1);
                            state_d = ST_CLEAR;
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q == 6'd0 || addr_q == LAST_ADDR) begin
                    cnt_d   = 6'd0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = addr_q + 10'd1;
                    cnt_d   = cnt_q - 6'd1;
                end
            end
`ifdef CFG_BUF_WRITER_CLEAR_EN
            ST_CLEAR: begin
                if (clr_q == 10'd0 || addr_q == LAST_ADDR) begin
                    clr_d   = 10'd0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = addr_q + 10'd1;
                    clr_d   = clr_q - 10'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            addr_q  <= 10'd0;
            data_q  <= 8'd0;
            cnt_q   <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CFG_BUF_WRITER_CLEAR_EN
            clr_q   <= 10'd0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef CFG_BUF_WRITER_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

endmodule

// File: tb/tb_config_buf_writer.sv
// Bench for config_buf_writer: directed literal cases plus random
// commands against a queue-based model of the expected write stream.
module tb_config_buf_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [4:0] cmd_row = 5'd0;
    logic [5:0] cmd_col = 6'd0;
    logic [5:0] cmd_len = 6'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       wr_valid;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // model state
    int   wq[$];
    bit   m_busy = 1'b0;
    bit   e_valid = 1'b0;
    int   e_addr = 0;
    int   e_data = 0;
    bit   e_done = 1'b0;
    bit   e_err = 1'b0;
    int   m_data = 0;

    config_buf_writer dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .cmd_valid_in       (cmd_valid),
        .cmd_ready_out      (cmd_ready),
        .cmd_op_in          (cmd_op),
        .cmd_row_in         (cmd_row),
        .cmd_col_in         (cmd_col),
        .cmd_len_in         (cmd_len),
        .cmd_data_in        (cmd_data),
        .buf_write_valid_out(wr_valid),
        .buf_write_addr_out (wr_addr),
        .buf_write_data_out (wr_data),
        .done_out           (done),
        .err_out            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        wq.delete();
        m_busy  = 1'b0;
        e_valid = 1'b0;
        e_addr  = 0;
        e_data  = 0;
        e_done  = 1'b0;
        e_err   = 1'b0;
    endfunction

    // Advance the model by one clock edge, given the inputs seen there
    function automatic void model_step();
        int start, count, n;
        bit legal;
        if (rst) begin
            model_reset();
            return;
        end
        e_valid = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        if (m_busy) begin
            if (wq.size() > 0) begin
                e_valid = 1'b1;
                e_addr  = wq.pop_front();
                e_data  = m_data;
            end else begin
                e_done = 1'b1;
                m_busy = 1'b0;
            end
        end else if (cmd_valid) begin
            legal = 1'b0;
            start = 0;
            count = 0;
            if (cmd_op == 2'd0 || cmd_op == 2'd1) begin
                legal = (int'(cmd_row) < 23) && (int'(cmd_col) < 40);
                start = int'(cmd_row) * 40 + int'(cmd_col);
                count = (cmd_op == 2'd0) ? 1 : int'(cmd_len);
            end
`ifdef CFG_BUF_WRITER_CLEAR_EN
            if (cmd_op == 2'd2) begin
                legal = 1'b1;
                start = 0;
                count = 920;
            end
`endif
            if (!legal) begin
                e_err = 1'b1;
            end else begin
                n = (start + count > 920) ? 920 - start : count;
                if (n == 0) begin
                    e_done = 1'b1;
                end else begin
                    for (int i = 0; i < n; i++) wq.push_back(start + i);
                    m_data  = int'(cmd_data);
                    m_busy  = 1'b1;
                    e_valid = 1'b1;
                    e_addr  = wq.pop_front();
                    e_data  = m_data;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Present one command once the model says the block is idle
    task automatic issue(input logic [1:0] op, input logic [4:0] row,
                         input logic [5:0] col, input logic [5:0] len,
                         input logic [7:0] data);
        int guard = 0;
        cmd_valid = 1'b0;
        while (m_busy && guard < 2000) begin
            tick();
            guard++;
        end
        if (m_busy) begin
            errors++;
            $display("FAIL idle_wait: got busy expected idle");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_len   = len;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid", int'(wr_valid), int'(e_valid));
            chk("addr", int'(wr_addr), e_addr);
            chk("data", int'(wr_data), e_data);
            chk("done", int'(done), int'(e_done));
            chk("err", int'(err), int'(e_err));
            chk("ready", int'(cmd_ready), int'(!m_busy));
        end
    end

    initial begin
        int wcount;
        int cyc;
        #1;
        chk("rst_valid", int'(wr_valid), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        tick();
        tick();
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_ready", int'(cmd_ready), 1);

        // single WRITE
        issue(2'd0, 5'd2, 6'd5, 6'd0, 8'h41);
        chk("w_valid", int'(wr_valid), 1);
        chk("w_addr", int'(wr_addr), 85);
        chk("w_data", int'(wr_data), 'h41);
        tick();
        chk("w_done", int'(done), 1);
        chk("w_ready", int'(cmd_ready), 1);
        chk("w_idle", int'(wr_valid), 0);

        // FILL across a row boundary
        issue(2'd1, 5'd0, 6'd38, 6'd4, 8'h20);
        for (int i = 0; i < 4; i++) begin
            chk("f_addr", int'(wr_addr), 38 + i);
            chk("f_valid", int'(wr_valid), 1);
            tick();
        end
        chk("f_done", int'(done), 1);

        // FILL truncated at the end of the buffer
        issue(2'd1, 5'd22, 6'd37, 6'd10, 8'h33);
        for (int i = 0; i < 3; i++) begin
            chk("e_addr", int'(wr_addr), 917 + i);
            tick();
        end
        chk("e_done", int'(done), 1);
        chk("e_nowr", int'(wr_valid), 0);
        chk("e_hold", int'(wr_addr), 919);

        // FILL of length zero
        issue(2'd1, 5'd3, 6'd3, 6'd0, 8'h11);
        chk("z_done", int'(done), 1);
        chk("z_nowr", int'(wr_valid), 0);

        // rejected commands
        issue(2'd0, 5'd23, 6'd0, 6'd0, 8'h01);
        chk("r_row", int'(err), 1);
        chk("r_ready", int'(cmd_ready), 1);
        issue(2'd0, 5'd0, 6'd40, 6'd0, 8'h01);
        chk("r_col", int'(err), 1);
        issue(2'd3, 5'd0, 6'd0, 6'd0, 8'h01);
        chk("r_op3", int'(err), 1);
        chk("r_nowr", int'(wr_valid), 0);

        // full CLEAR
        issue(2'd2, 5'd0, 6'd0, 6'd0, 8'h00);
`ifdef CFG_BUF_WRITER_CLEAR_EN
        wcount = 0;
        cyc = 1;
        while (!done && cyc < 1000) begin
            if (wr_valid) begin
                if (int'(wr_addr) != wcount) chk("c_seq", int'(wr_addr), wcount);
                wcount++;
            end
            tick();
            cyc++;
        end
        chk("c_writes", wcount, 920);
        chk("c_done_cyc", cyc, 921);
`else
        chk("c_err", int'(err), 1);
        chk("c_nowr", int'(wr_valid), 0);
        wcount = 0;
        cyc = 0;
`endif

        // reset in the middle of a long run
`ifdef CFG_BUF_WRITER_CLEAR_EN
        issue(2'd2, 5'd0, 6'd0, 6'd0, 8'h5a);
`else
        issue(2'd1, 5'd0, 6'd0, 6'd63, 8'h5a);
`endif
        for (int i = 0; i < 9; i++) tick();
        chk("m_tenth", int'(wr_addr), 9);
        rst = 1'b1;
        model_reset();
        #1;
        chk("m_drop", int'(wr_valid), 0);
        chk("m_addr0", int'(wr_addr), 0);
        tick();
        rst = 1'b0;
        chk("m_ready", int'(cmd_ready), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("m_quiet", int'(wr_valid), 0);
        end
        issue(2'd0, 5'd1, 6'd1, 6'd0, 8'h07);
        chk("m_next", int'(wr_addr), 41);
        chk("m_nextv", int'(wr_valid), 1);

        // random traffic checked by the compare process
        for (int c = 0; c < 6000; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            if (cmd_op == 2'd2 && $urandom_range(0, 15) != 0) cmd_op = 2'd1;
            cmd_row   = ($urandom_range(0, 3) == 0) ? 5'd22 : 5'($urandom_range(0, 24));
            cmd_col   = 6'($urandom_range(0, 42));
            cmd_len   = 6'($urandom_range(0, 63));
            cmd_data  = 8'($urandom_range(0, 255));
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 1000 && m_busy; i++) tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_buf_writer.md
CONFIG_BUF_WRITER -- requirements
Module: config_buf_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning tile columns per buffer row.
REQ-002 SHALL have parameter ROWS, default 23, meaning tile rows in the buffer.
REQ-003 SHALL have port clk_in, input, 1, the single clock.
REQ-004 SHALL have port rst_in, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port cmd_valid_in, input, 1, command offered.
REQ-006 SHALL have port cmd_ready_out, output, 1, command accepted when high together with cmd_valid_in.
REQ-007 SHALL have port cmd_op_in, input, 2, opcode: 0 = WRITE, 1 = FILL, 2 = CLEAR, 3 = reserved.
REQ-008 SHALL have port cmd_row_in, input, 5, start row.
REQ-009 SHALL have port cmd_col_in, input, 6, start column.
REQ-010 SHALL have port cmd_len_in, input, 6, FILL tile count.
REQ-011 SHALL have port cmd_data_in, input, 8, tile index to write.
REQ-012 SHALL have port buf_write_valid_out, output, 1, buffer write strobe.
REQ-013 SHALL have port buf_write_addr_out, output, 10, buffer address.
REQ-014 SHALL have port buf_write_data_out, output, 8, tile index written.
REQ-015 SHALL have port done_out, output, 1, one-cycle pulse when a command completes.
REQ-016 SHALL have port err_out, output, 1, one-cycle pulse when a command is rejected.

Function
REQ-017 SHALL implement states IDLE, RUN and CLEAR; cmd_ready_out SHALL be high only in IDLE.
REQ-018 On accept (cycle N), the block SHALL latch the address row*COLS+col (shift-add, 10 bits), the data and the remaining count.
- WRITE: count = 1.
- FILL: count = cmd_len_in.
- CLEAR: address 0, count = ROWS*COLS.
REQ-019 Out-of-range commands SHALL be rejected:
- Condition: row >= ROWS, col >= COLS, or op 3.
- Response: no writes; err_out pulses in cycle N+1; return to IDLE.
REQ-020 The first write SHALL appear in cycle N+1, then one write per cycle at consecutive addresses; all write outputs SHALL be registered.
REQ-021 A run reaching column COLS-1 SHALL continue at column 0 of the next row (linear address +1).
REQ-022 A run SHALL stop after address ROWS*COLS-1 (919), even if count remains; the address SHALL never wrap to 0.
REQ-023 FILL with cmd_len_in = 0 SHALL produce no writes and pulse done_out in cycle N+1.
REQ-024 done_out SHALL pulse in the cycle after the last write; the state SHALL be IDLE in that same cycle, so cmd_ready_out is high.
REQ-025 A command of L writes SHALL therefore have throughput L+1 cycles.
REQ-026 buf_write_valid_out SHALL be low whenever no write is issued; addr and data SHALL hold their last values.
REQ-027 done_out and err_out SHALL never be high in the same cycle.

Reset
REQ-028 Asserting rst_in at any time, including mid-run, SHALL immediately force:
- state IDLE;
- buf_write_valid_out, done_out and err_out to 0;
- buf_write_addr_out to 0 and buf_write_data_out to 0;
- the internal count to 0.
REQ-029 An aborted run SHALL NOT resume after reset; cmd_ready_out SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-030 With macro CFG_BUF_WRITER_CLEAR_EN defined, op 2 (CLEAR) SHALL be supported as in REQ-018 and SHALL use the CLEAR state.
REQ-031 Without CFG_BUF_WRITER_CLEAR_EN:
- op 2 SHALL be rejected per REQ-019;
- the CLEAR state and its 10-bit full-buffer counter SHALL be absent.

Structure
REQ-032 A shared package cfg_pkg SHALL hold:
- CFG_COLS = 40, CFG_ROWS = 23, CFG_BUF_DEPTH = 920;
- the opcode enum typedef cfg_op_t;
- the state typedef.
REQ-033 One sub-module, cfg_addr_calc, SHALL compute row*COLS+col and the range check combinationally.

Verification
REQ-034 WRITE at row 2, col 5, data 0x41 -> a single write with addr 85, data 0x41 in cycle N+1; done_out in N+2.
REQ-035 FILL at row 0, col 38, len 4, data 0x20 -> writes at addrs 38, 39, 40, 41; done_out the cycle after.
REQ-036 FILL at row 22, col 37, len 10 -> writes at addrs 917, 918, 919 only; then done_out; no address 0 write.
REQ-037 WRITE at row 23, or WRITE at col 40, or op 3 -> no write; err_out pulse in N+1; cmd_ready_out high in N+1.
REQ-038 CLEAR with data 0x00 and the macro defined -> 920 writes at addrs 0..919, done_out at N+921.
- Without the macro: err_out only.
REQ-039 rst_in asserted during write 10 of a CLEAR -> valid_out drops at once; no further writes after release; the next WRITE is accepted normally.
